// File: rtl/alarm_ring_ctrl_pkg.sv
// Shared constants, state encoding and counter widths for alarm_ring_ctrl.
package alarm_ring_ctrl_pkg;

    localparam int unsigned MSC_N        = 5;
    localparam logic [9:0]  VOL_DEFAULT  = 10'b0000_1_0000_0;

    localparam int unsigned RING_CNT_W   = 8;
    localparam int unsigned SN_CNT_W     = 10;
    localparam int unsigned SNOOZE_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_e;

endpackage

// File: rtl/alarm_ring_ctrl_match.sv
// Per-channel HH:MM:00 comparator; emits a single-cycle pulse on the first cycle of a match.
module alarm_match (
    input  logic        sysclk,
    input  logic        rst,
    input  logic [23:0] time_bcd,
    input  logic [15:0] alarm_bcd,
    input  logic        alarm_en,
    output logic        match_pulse
);

    logic match_now;
    logic match_prev;

    assign match_now = alarm_en && (time_bcd[23:8] == alarm_bcd) && (time_bcd[7:0] == 8'h00);

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            match_prev <= 1'b0;
        end else begin
            match_prev <= match_now;
        end
    end

    assign match_pulse = match_now && !match_prev;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Multi-channel alarm controller: match detection, pending arbitration, ring/snooze FSM.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_ring_ctrl
    import alarm_ring_ctrl_pkg::*;
#(
    parameter int unsigned N_ALARM    = 4,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic                   sysclk,
    input  logic                   rst,
    input  logic                   tick_1hz,
    input  logic [23:0]            time_bcd,
    input  logic [16*N_ALARM-1:0]  alarm_bcd,
    input  logic [N_ALARM-1:0]     alarm_en,
    input  logic                   stop,
    input  logic                   snooze,
    input  logic                   beep_on,
    output logic                   ringing,
    output logic [2:0]             ring_ch,
    output logic [N_ALARM-1:0]     led,
    output logic [MSC_N-1:0]       start,
    output logic [9:0]             volume
);

    logic [N_ALARM-1:0]    match_pulse;
    logic [N_ALARM-1:0]    pend;
    logic [N_ALARM-1:0]    active_mask;
    logic [N_ALARM-1:0]    grant_mask;
    logic [2:0]            grant_idx;
    logic                  ch_en;
    state_e                state;
    logic [RING_CNT_W-1:0] ring_cnt;
`ifdef ALARM_SNOOZE_EN
    logic [SN_CNT_W-1:0]     sn_cnt;
    logic [SNOOZE_CNT_W-1:0] snooze_cnt;
`else
    logic unused_snooze;
    assign unused_snooze = snooze ^ ((SNOOZE_SEC + MAX_SNOOZE) == 0);
`endif

    for (genvar k = 0; k < N_ALARM; k++) begin : g_match
        alarm_match u_match (
            .sysclk      (sysclk),
            .rst         (rst),
            .time_bcd    (time_bcd),
            .alarm_bcd   (alarm_bcd[16*k +: 16]),
            .alarm_en    (alarm_en[k]),
            .match_pulse (match_pulse[k])
        );
    end

    // Lowest set index wins.
    always_comb begin
        grant_idx = '0;
        for (int k = N_ALARM - 1; k >= 0; k--) begin
            if (pend[k]) grant_idx = 3'(k);
        end
    end

    always_comb begin
        active_mask = '0;
        grant_mask  = '0;
        for (int k = 0; k < N_ALARM; k++) begin
            active_mask[k] = (state != ST_IDLE) && (ring_ch == 3'(k));
            grant_mask[k]  = (state == ST_IDLE) && (grant_idx == 3'(k)) && pend[k];
        end
    end

    assign ch_en = |(alarm_en & active_mask);

    // Matches on the channel being serviced (or just granted) are dropped.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= ((pend & ~grant_mask) | (match_pulse & ~active_mask & ~grant_mask)) & alarm_en;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            ringing    <= 1'b0;
            ring_ch    <= '0;
            ring_cnt   <= '0;
`ifdef ALARM_SNOOZE_EN
            sn_cnt     <= '0;
            snooze_cnt <= '0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|pend) begin
                        state      <= ST_RING;
                        ringing    <= 1'b1;
                        ring_ch    <= grant_idx;
                        ring_cnt   <= RING_CNT_W'(RING_SEC);
`ifdef ALARM_SNOOZE_EN
                        snooze_cnt <= '0;
`endif
                    end
                end
                ST_RING: begin
                    if (stop || !ch_en) begin
                        state    <= ST_IDLE;
                        ringing  <= 1'b0;
                        ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze && (snooze_cnt < SNOOZE_CNT_W'(MAX_SNOOZE))) begin
                        state      <= ST_SNOOZE;
                        ringing    <= 1'b0;
                        sn_cnt     <= SN_CNT_W'(SNOOZE_SEC);
                        snooze_cnt <= snooze_cnt + SNOOZE_CNT_W'(1);
`endif
                    end else if (tick_1hz) begin
                        if (ring_cnt <= RING_CNT_W'(1)) begin
                            state    <= ST_IDLE;
                            ringing  <= 1'b0;
                            ring_cnt <= '0;
                        end else begin
                            ring_cnt <= ring_cnt - RING_CNT_W'(1);
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    if (stop || !ch_en) begin
                        state  <= ST_IDLE;
                        sn_cnt <= '0;
                    end else if (tick_1hz) begin
                        if (sn_cnt <= SN_CNT_W'(1)) begin
                            state    <= ST_RING;
                            ringing  <= 1'b1;
                            sn_cnt   <= '0;
                            ring_cnt <= RING_CNT_W'(RING_SEC);
                        end else begin
                            sn_cnt <= sn_cnt - SN_CNT_W'(1);
                        end
                    end
                end
`endif
                default: begin
                    state   <= ST_IDLE;
                    ringing <= 1'b0;
                end
            endcase
        end
    end

    assign led    = pend | active_mask;
    assign volume = VOL_DEFAULT;

    always_comb begin
        start = '0;
        for (int unsigned j = 0; j < MSC_N; j++) begin
            start[j] = ringing && beep_on && ((32'(ring_ch) % MSC_N) == j);
        end
    end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Self-checking bench for alarm_ring_ctrl; expected ring channels are queued at stimulus time.
module tb_alarm_ring_ctrl;

    logic        sysclk = 1'b0;
    logic        rst;
    logic        tick_1hz;
    logic [23:0] time_bcd;
    logic [63:0] alarm_bcd;
    logic [3:0]  alarm_en;
    logic        stop;
    logic        snooze;
    logic        beep_on;
    logic        ringing;
    logic [2:0]  ring_ch;
    logic [3:0]  led;
    logic [4:0]  start;
    logic [9:0]  volume;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    always #5 sysclk = ~sysclk;

    alarm_ring_ctrl dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .time_bcd  (time_bcd),
        .alarm_bcd (alarm_bcd),
        .alarm_en  (alarm_en),
        .stop      (stop),
        .snooze    (snooze),
        .beep_on   (beep_on),
        .ringing   (ringing),
        .ring_ch   (ring_ch),
        .led       (led),
        .start     (start),
        .volume    (volume)
    );

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick_1hz = 0; stop = 0; snooze = 0; beep_on = 1;
        time_bcd = 24'h235959; alarm_bcd = '0; alarm_en = '0;
        step(); step();
        checks++; if (ringing !== 1'b0) begin failures++; $display("FAIL reset_ringing got=%0b want=0", ringing); end
        checks++; if (ring_ch !== 3'd0) begin failures++; $display("FAIL reset_ring_ch got=%0d want=0", ring_ch); end
        checks++; if (led !== 4'b0) begin failures++; $display("FAIL reset_led got=%b want=0000", led); end
        checks++; if (start !== 5'b0) begin failures++; $display("FAIL reset_start got=%b want=00000", start); end
        checks++; if (volume !== 10'd32) begin failures++; $display("FAIL volume got=%b want=0000100000", volume); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        int e;
        alarm_bcd[31:16] = 16'h0730; alarm_en = 4'b0010; beep_on = 1;
        step();
        time_bcd = 24'h073000; exp_q.push_back(1);
        step();
        checks++; if (led !== 4'b0010) begin failures++; $display("FAIL single_pend got=%b want=0010", led); end
        checks++; if (ringing !== 1'b0) begin failures++; $display("FAIL single_early got=%0b want=0", ringing); end
        step();
        checks++; if (ringing !== 1'b1) begin failures++; $display("FAIL single_ring got=%0b want=1", ringing); end
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL single_pop got=empty want=entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (ring_ch !== 3'(e)) begin failures++; $display("FAIL single_ch got=%0d want=%0d", ring_ch, e); end
            checks++; if (start !== 5'(1 << (e % 5))) begin failures++; $display("FAIL single_start got=%b want=%b", start, 5'(1 << (e % 5))); end
        end
        checks++; if (led !== 4'b0010) begin failures++; $display("FAIL single_led got=%b want=0010", led); end
        time_bcd = 24'h073105; stop = 1;
        step();
        stop = 0;
        checks++; if (ringing !== 1'b0) begin failures++; $display("FAIL single_stop got=%0b want=0", ringing); end
        checks++; if (led !== 4'b0) begin failures++; $display("FAIL single_stop_led got=%b want=0000", led); end
    endtask

    task automatic test_back_to_back();
        int e;
        alarm_bcd = '0; alarm_bcd[15:0] = 16'h0600; alarm_bcd[47:32] = 16'h0600;
        alarm_en = 4'b0101; beep_on = 1;
        step();
        time_bcd = 24'h060000; exp_q.push_back(0); exp_q.push_back(2);
        step(); step();
        time_bcd = 24'h060001;
        checks++; if (ringing !== 1'b1) begin failures++; $display("FAIL b2b_first got=%0b want=1", ringing); end
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL b2b_pop0 got=empty want=entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (ring_ch !== 3'(e)) begin failures++; $display("FAIL b2b_ch0 got=%0d want=%0d", ring_ch, e); end
        end
        checks++; if (led !== 4'b0101) begin failures++; $display("FAIL b2b_led got=%b want=0101", led); end
        repeat (59) pulse_tick();
        checks++; if (ringing !== 1'b1) begin failures++; $display("FAIL b2b_tick59 got=%0b want=1", ringing); end
        pulse_tick();
        checks++; if (ringing !== 1'b0) begin failures++; $display("FAIL b2b_timeout got=%0b want=0", ringing); end
        checks++; if (led !== 4'b0100) begin failures++; $display("FAIL b2b_gap_led got=%b want=0100", led); end
        step();
        checks++; if (ringing !== 1'b1) begin failures++; $display("FAIL b2b_second got=%0b want=1", ringing); end
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL b2b_pop1 got=empty want=entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (ring_ch !== 3'(e)) begin failures++; $display("FAIL b2b_ch1 got=%0d want=%0d", ring_ch, e); end
            checks++; if (start !== 5'(1 << (e % 5))) begin failures++; $display("FAIL b2b_start got=%b want=%b", start, 5'(1 << (e % 5))); end
        end
        beep_on = 0;
        step();
        checks++; if (start !== 5'b0) begin failures++; $display("FAIL b2b_mute got=%b want=00000", start); end
        beep_on = 1; stop = 1;
        step();
        stop = 0;
        checks++; if (led !== 4'b0) begin failures++; $display("FAIL b2b_stop_led got=%b want=0000", led); end
    endtask

    task automatic test_enable_drop();
        int e;
        alarm_bcd = '0; alarm_bcd[15:0] = 16'h1000; alarm_bcd[63:48] = 16'h1000;
        alarm_en = 4'b1001;
        step();
        time_bcd = 24'h100000; exp_q.push_back(0);
        step(); step();
        time_bcd = 24'h100001;
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL endrop_pop got=empty want=entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (ring_ch !== 3'(e) || ringing !== 1'b1) begin failures++; $display("FAIL endrop_ring got=%0d/%0b want=%0d/1", ring_ch, ringing, e); end
        end
        checks++; if (led !== 4'b1001) begin failures++; $display("FAIL endrop_led got=%b want=1001", led); end
        alarm_en = 4'b0001;
        step();
        checks++; if (led !== 4'b0001) begin failures++; $display("FAIL endrop_pend got=%b want=0001", led); end
        alarm_en = 4'b0000;
        step();
        checks++; if (ringing !== 1'b0 || led !== 4'b0) begin failures++; $display("FAIL endrop_ring_exit got=%0b/%b want=0/0000", ringing, led); end
        alarm_en = 4'b1001;
        repeat (5) step();
        checks++; if (ringing !== 1'b0 || led !== 4'b0) begin failures++; $display("FAIL endrop_never got=%0b/%b want=0/0000", ringing, led); end
    endtask

    task automatic test_snooze();
        int e;
        alarm_bcd = '0; alarm_bcd[31:16] = 16'h0915; alarm_en = 4'b0010;
        step();
        time_bcd = 24'h091500; exp_q.push_back(1);
        step(); step();
        time_bcd = 24'h091501;
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL snz_pop got=empty want=entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (ring_ch !== 3'(e) || ringing !== 1'b1) begin failures++; $display("FAIL snz_ring got=%0d/%0b want=%0d/1", ring_ch, ringing, e); end
        end
`ifdef ALARM_SNOOZE_EN
        for (int n = 0; n < 3; n++) begin
            snooze = 1;
            step();
            snooze = 0;
            checks++; if (ringing !== 1'b0 || led !== 4'b0010) begin failures++; $display("FAIL snz_enter%0d got=%0b/%b want=0/0010", n, ringing, led); end
            repeat (299) pulse_tick();
            checks++; if (ringing !== 1'b0) begin failures++; $display("FAIL snz_hold%0d got=%0b want=0", n, ringing); end
            exp_q.push_back(1);
            pulse_tick();
            checks++; if (ringing !== 1'b1) begin failures++; $display("FAIL snz_back%0d got=%0b want=1", n, ringing); end
            if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL snz_pop%0d got=empty want=entry", n); end
            else begin
                e = exp_q.pop_front();
                checks++; if (ring_ch !== 3'(e)) begin failures++; $display("FAIL snz_ch%0d got=%0d want=%0d", n, ring_ch, e); end
            end
        end
        snooze = 1;
        step();
        snooze = 0;
        checks++; if (ringing !== 1'b1) begin failures++; $display("FAIL snz_fourth got=%0b want=1", ringing); end
        stop = 1;
        step();
        stop = 0;
        time_bcd = 24'h091500; exp_q.push_back(1);
        step(); step();
        time_bcd = 24'h091501;
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL snz_pop_b got=empty want=entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (ringing !== 1'b1 || ring_ch !== 3'(e)) begin failures++; $display("FAIL snz_ring_b got=%0b/%0d want=1/%0d", ringing, ring_ch, e); end
        end
        stop = 1; snooze = 1;
        step();
        stop = 0; snooze = 0;
        repeat (3) pulse_tick();
        checks++; if (ringing !== 1'b0 || led !== 4'b0) begin failures++; $display("FAIL snz_stop_wins got=%0b/%b want=0/0000", ringing, led); end
        time_bcd = 24'h091500; exp_q.push_back(1);
        step(); step();
        time_bcd = 24'h091501;
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL snz_pop_c got=empty want=entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (ringing !== 1'b1 || ring_ch !== 3'(e)) begin failures++; $display("FAIL snz_ring_c got=%0b/%0d want=1/%0d", ringing, ring_ch, e); end
        end
        snooze = 1;
        step();
        snooze = 0; alarm_en = 4'b0000;
        step();
        checks++; if (led !== 4'b0) begin failures++; $display("FAIL snz_disable got=%b want=0000", led); end
        alarm_en = 4'b0010;
        repeat (302) pulse_tick();
        checks++; if (ringing !== 1'b0) begin failures++; $display("FAIL snz_no_return got=%0b want=0", ringing); end
`else
        snooze = 1;
        step();
        snooze = 0;
        checks++; if (ringing !== 1'b1 || led !== 4'b0010) begin failures++; $display("FAIL nosnz_ignored got=%0b/%b want=1/0010", ringing, led); end
        repeat (3) pulse_tick();
        checks++; if (ringing !== 1'b1) begin failures++; $display("FAIL nosnz_still got=%0b want=1", ringing); end
        stop = 1;
        step();
        stop = 0;
`endif
    endtask

    task automatic test_reset_mid_ring();
        int e;
        alarm_bcd = '0; alarm_bcd[15:0] = 16'h1100; alarm_bcd[63:48] = 16'h1100;
        alarm_en = 4'b1001;
        step();
        time_bcd = 24'h110000; exp_q.push_back(0);
        step(); step();
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL rstmid_pop got=empty want=entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (ringing !== 1'b1 || ring_ch !== 3'(e)) begin failures++; $display("FAIL rstmid_ring got=%0b/%0d want=1/%0d", ringing, ring_ch, e); end
        end
        checks++; if (led !== 4'b1001) begin failures++; $display("FAIL rstmid_led got=%b want=1001", led); end
        #2;
        rst = 1;
        #1;
        checks++; if (ringing !== 1'b0 || led !== 4'b0 || start !== 5'b0) begin failures++; $display("FAIL rstmid_async got=%0b/%b/%b want=0/0000/00000", ringing, led, start); end
        time_bcd = 24'h110001;
        step(); step();
        rst = 0;
        repeat (5) step();
        checks++; if (ringing !== 1'b0 || led !== 4'b0) begin failures++; $display("FAIL rstmid_after got=%0b/%b want=0/0000", ringing, led); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_snooze();
        test_reset_mid_ring();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
